// File: rtl/robo_pkg.sv
// Shared constants for the motion controller and the navigation FSM bench:
// 3-bit state codes, default timing parameters and a counter-width helper.
package robo_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FWD   = 3'd1;
  localparam logic [2:0] ST_ROT   = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam int DEF_DIV       = 8;
  localparam int DEF_DWELL     = 4;
  localparam int DEF_GAP       = 2;
  localparam int DEF_ROT_LIMIT = 64;

  // Bits needed to hold the value n itself (at least one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/robo_motion_ctrl_if.sv
// Command/status bundle between the navigation FSM (master) and the
// motion controller (slave).
interface robo_motion_if;

  logic       enable;
  logic       avancar;
  logic       girar;
  logic       clear;
  logic       motor_fwd;
  logic       motor_rot;
  logic       step;
  logic       busy;
  logic       stuck;
  logic [2:0] state;

  modport master (
    output enable, avancar, girar, clear,
    input  motor_fwd, motor_rot, step, busy, stuck, state
  );

  modport slave (
    input  enable, avancar, girar, clear,
    output motor_fwd, motor_rot, step, busy, stuck, state
  );

endinterface

// File: rtl/robo_step_prescaler.sv
// Step-rate divider: counts DIV falling edges while running and emits a
// registered one-cycle step pulse. tick marks the wrap edge combinationally
// so the parent can count steps on the same edge the pulse is launched.
module robo_step_prescaler
  import robo_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic zero,
  input  logic run,
  output logic tick,
  output logic step
);

  localparam int W = cnt_w(DIV - 1);

  logic [W-1:0] div_cnt;

  assign tick = run && (div_cnt == W'(DIV - 1));

  // Divider count and step pulse; the pulse is suppressed on any state change
  // so it never appears outside FWD/ROT.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      step    <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (zero || !run || tick) div_cnt <= '0;
      else                      div_cnt <= div_cnt + 1'b1;
      step <= tick && !zero;
    end
  end

endmodule

// File: rtl/robo_motion_ctrl.sv
// Motion sequencer between the wall-following FSM and the motor driver:
// dwell per command, motors-off gap on reversal, rotate-stuck watchdog.
// All state advances on the falling clock edge, like the navigation FSM.
module robo_motion_ctrl
  import robo_pkg::*;
#(
  parameter int DIV       = DEF_DIV,
  parameter int DWELL     = DEF_DWELL,
  parameter int GAP       = DEF_GAP,
  parameter int ROT_LIMIT = DEF_ROT_LIMIT
) (
  input  logic          clock,
  input  logic          reset,
  robo_motion_if.slave  bus
);

  localparam int DWW = cnt_w(DWELL);
  localparam int GPW = cnt_w(GAP);
  localparam int RLW = cnt_w(ROT_LIMIT);

  logic [2:0]     cur_state, nxt_state;
  logic [2:0]     gap_tgt, nxt_tgt;
  logic [DWW-1:0] dwell_cnt;
  logic [GPW-1:0] gap_cnt;
  logic [RLW-1:0] rot_cnt;
  logic           req_fwd, req_rot;
  logic           dwell_met, gap_done, fault_hit;
  logic           running, chg, tick;

  // girar wins when both requests are high.
  assign req_rot   = bus.enable & bus.girar;
  assign req_fwd   = bus.enable & bus.avancar & ~bus.girar;
  assign dwell_met = (dwell_cnt == DWW'(DWELL));
  assign gap_done  = (gap_cnt == GPW'(GAP - 1));
  assign running   = (cur_state == ST_FWD) || (cur_state == ST_ROT);
  assign fault_hit = (cur_state == ST_ROT) && tick && (rot_cnt == RLW'(ROT_LIMIT - 1));
  assign chg       = (nxt_state != cur_state);

  robo_step_prescaler #(.DIV(DIV)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .zero  (chg),
    .run   (running),
    .tick  (tick),
    .step  (bus.step)
  );

  // Next-state and gap-target selection.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    nxt_state = cur_state;
    nxt_tgt   = gap_tgt;
    case (cur_state)
      ST_IDLE: begin
        if (req_fwd)      nxt_state = ST_FWD;
        else if (req_rot) nxt_state = ST_ROT;
      end
      ST_FWD: begin
        if (!bus.enable) nxt_state = ST_IDLE;
        else if (dwell_met && req_rot) begin
          nxt_state = ST_GAP;
          nxt_tgt   = ST_ROT;
        end else if (dwell_met && !req_fwd) nxt_state = ST_IDLE;
      end
      ST_ROT: begin
        if (fault_hit)   nxt_state = ST_FAULT;
        else if (!bus.enable) nxt_state = ST_IDLE;
        else if (dwell_met && req_fwd) begin
          nxt_state = ST_GAP;
          nxt_tgt   = ST_FWD;
        end else if (dwell_met && !req_rot) nxt_state = ST_IDLE;
      end
      ST_GAP: begin
        if (!bus.enable) nxt_state = ST_IDLE;
        else if (gap_done) begin
          if ((gap_tgt == ST_ROT) ? req_rot : req_fwd) nxt_state = gap_tgt;
          else if (req_rot)                            nxt_state = ST_ROT;
          else if (req_fwd)                            nxt_state = ST_FWD;
          else                                         nxt_state = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (bus.clear) nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // State register and pending gap target.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      cur_state <= ST_IDLE;
      gap_tgt   <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
      gap_tgt   <= nxt_tgt;
    end
  end

  // Dwell, gap and rotate-watchdog counters; dwell and gap restart on every state change.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      dwell_cnt <= '0;
      gap_cnt   <= '0;
      rot_cnt   <= '0;
    end else begin
      if (chg)                    dwell_cnt <= '0;
      else if (tick && !dwell_met) dwell_cnt <= dwell_cnt + 1'b1;

      if (cur_state == ST_GAP && !chg) gap_cnt <= gap_cnt + 1'b1;
      else                             gap_cnt <= '0;

      if (nxt_state == ST_FWD && cur_state != ST_FWD)  rot_cnt <= '0;
      else if (cur_state == ST_FAULT && bus.clear)     rot_cnt <= '0;
      else if (cur_state == ST_ROT && tick && rot_cnt != RLW'(ROT_LIMIT))
        rot_cnt <= rot_cnt + 1'b1;
    end
  end

  assign bus.motor_fwd = (cur_state == ST_FWD);
  assign bus.motor_rot = (cur_state == ST_ROT);
  assign bus.busy      = (cur_state == ST_GAP);
  assign bus.stuck     = (cur_state == ST_FAULT);
  assign bus.state     = cur_state;

endmodule

// File: tb/tb_robo_motion_ctrl.sv
// Directed bench for robo_motion_ctrl (DIV=8, DWELL=4, GAP=2, ROT_LIMIT=5).
// Inputs change and outputs are sampled on the rising edge; the DUT acts on
// the falling edge, so edge k below is the k-th falling edge after a request.
module tb_robo_motion_ctrl;
  import robo_pkg::*;

  logic clock;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  robo_motion_if bus ();

  robo_motion_ctrl #(
    .DIV       (8),
    .DWELL     (4),
    .GAP       (2),
    .ROT_LIMIT (5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Each call lets exactly n falling edges pass and returns on a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.enable  = 1'b0;
    bus.avancar = 1'b0;
    bus.girar   = 1'b0;
    bus.clear   = 1'b0;
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_state", bus.state, ST_IDLE);
    check("rst_fwd", bus.motor_fwd, 0);
    check("rst_rot", bus.motor_rot, 0);
    check("rst_step", bus.step, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_stuck", bus.stuck, 0);

    // Forward: enable on first edge, step after edges 8, 16, 24
    bus.enable = 1'b1; bus.avancar = 1'b1;
    cyc(1);
    check("fwd_entry_state", bus.state, ST_FWD);
    check("fwd_entry_motor", bus.motor_fwd, 1);
    check("fwd_entry_step", bus.step, 0);
    for (int i = 1; i <= 24; i++) begin
      cyc(1);
      check("fwd_step", bus.step, (i % 8 == 0) ? 1 : 0);
      check("fwd_motor_rot", bus.motor_rot, 0);
      check("fwd_motor_fwd", bus.motor_fwd, 1);
    end

    // Reversal: girar after 1st step, FWD held to 4th step, 2-cycle gap, then ROT
    do_reset();
    bus.enable = 1'b1; bus.avancar = 1'b1;
    cyc(1);
    cyc(8);
    check("rev_first_step", bus.step, 1);
    bus.girar = 1'b1;
    for (int i = 9; i <= 35; i++) begin
      logic [2:0] exp_st;
      cyc(1);
      exp_st = (i <= 32) ? ST_FWD : (i <= 34) ? ST_GAP : ST_ROT;
      check("rev_state", bus.state, exp_st);
      check("rev_busy", bus.busy, (exp_st == ST_GAP) ? 1 : 0);
      check("rev_step", bus.step, (i == 16 || i == 24 || i == 32) ? 1 : 0);
      check("rev_motor_fwd", bus.motor_fwd, (exp_st == ST_FWD) ? 1 : 0);
      check("rev_motor_rot", bus.motor_rot, (exp_st == ST_ROT) ? 1 : 0);
    end

    // Both requests from IDLE: rotate wins; held rotate faults on 5th step
    do_reset();
    bus.enable = 1'b1; bus.avancar = 1'b1; bus.girar = 1'b1;
    cyc(1);
    check("prio_state", bus.state, ST_ROT);
    check("prio_motor_rot", bus.motor_rot, 1);
    check("prio_motor_fwd", bus.motor_fwd, 0);
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      check("wd_state", bus.state, (i < 40) ? ST_ROT : ST_FAULT);
      check("wd_step", bus.step, (i % 8 == 0 && i < 40) ? 1 : 0);
    end
    check("wd_stuck", bus.stuck, 1);
    check("wd_motor_rot", bus.motor_rot, 0);
    bus.enable = 1'b0;
    cyc(3);
    check("fault_en0_state", bus.state, ST_FAULT);
    bus.enable = 1'b1;
    cyc(3);
    check("fault_hold_state", bus.state, ST_FAULT);
    check("fault_hold_fwd", bus.motor_fwd, 0);
    check("fault_hold_rot", bus.motor_rot, 0);
    check("fault_hold_step", bus.step, 0);
    bus.clear = 1'b1;
    cyc(1);
    check("clear_state", bus.state, ST_IDLE);
    check("clear_stuck", bus.stuck, 0);
    bus.clear = 1'b0;
    cyc(1);
    check("rearm_entry", bus.state, ST_ROT);
    cyc(39);
    check("rearm_before_limit", bus.state, ST_ROT);
    cyc(1);
    check("rearm_limit", bus.state, ST_FAULT);
    bus.girar = 1'b0; bus.avancar = 1'b0; bus.clear = 1'b1;
    cyc(1);
    check("rearm_clear", bus.state, ST_IDLE);
    bus.clear = 1'b0;

    // Enable dropped mid-dwell after step 2: IDLE on next edge, no more steps
    do_reset();
    bus.enable = 1'b1; bus.avancar = 1'b1;
    cyc(1);
    cyc(16);
    check("drop_step2", bus.step, 1);
    bus.enable = 1'b0;
    cyc(1);
    check("drop_state", bus.state, ST_IDLE);
    check("drop_motor", bus.motor_fwd, 0);
    check("drop_step", bus.step, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("drop_quiet_step", bus.step, 0);
    end

    // Async reset between edges while ROT is stepping
    do_reset();
    bus.enable = 1'b1; bus.girar = 1'b1;
    cyc(1);
    cyc(8);
    check("ar_pre_step", bus.step, 1);
    check("ar_pre_rot", bus.motor_rot, 1);
    #2 reset = 1'b1;
    #1;
    check("ar_motor_rot", bus.motor_rot, 0);
    check("ar_step", bus.step, 0);
    check("ar_busy", bus.busy, 0);
    check("ar_state", bus.state, ST_IDLE);
    @(posedge clock);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/robo_motion_ctrl.md
Name: robo_motion_ctrl

Overview:
- Sits between the wall-following navigation FSM outputs (avancar, girar) and the motor driver.
- Turns level commands into sequenced motor enables plus a periodic step pulse.
- Enforces a minimum dwell per command and an idle gap on every forward/rotate reversal.
- Detects a robot stuck rotating and latches a fault until cleared.

Parameters:
DIV, 8, clock cycles per step pulse (>=2)
DWELL, 4, minimum step pulses a FWD/ROT command is held before a change is honoured (>=1)
GAP, 2, clock cycles of motors-off between FWD and ROT in either direction (>=1)
ROT_LIMIT, 64, consecutive rotate steps without forward motion before FAULT (>=1)

Ports:
clock  in  1  system clock; all state updates on falling edge, same as navigation FSM
reset  in  1  asynchronous, active-high; forces IDLE and clears all counters
enable  in  1  run permission; 0 stops motion
avancar  in  1  forward request from navigation FSM
girar  in  1  rotate request from navigation FSM
clear  in  1  fault acknowledge
motor_fwd  out  1  forward motor enable
motor_rot  out  1  rotate motor enable
step  out  1  one-cycle pulse per motion step
busy  out  1  high in GAP
stuck  out  1  high in FAULT
state  out  3  current state code, for debug

Behaviour:
- Reset values: all outputs 0, state = IDLE, all counters 0.
- Request decode (combinational):
  - req_rot = enable & girar (girar has priority when both are high).
  - req_fwd = enable & avancar & !girar.
  - Otherwise no request.
- States: IDLE=0, FWD=1, ROT=2, GAP=3, FAULT=4.
- Outputs are Moore, decoded from registered state:
  - motor_fwd = (FWD), motor_rot = (ROT), busy = (GAP), stuck = (FAULT).
  - step is a registered pulse.
- Prescaler:
  - div_cnt counts 0..DIV-1 only in FWD/ROT; it is zeroed on entry.
  - step = 1 for the one cycle after div_cnt == DIV-1, so the first pulse arrives DIV cycles after entry.
  - step is never high outside FWD/ROT.
- Dwell: dwell_cnt counts step pulses since entry to FWD/ROT and saturates at DWELL. A command change is honoured only when dwell_cnt == DWELL.
- Rotate watchdog:
  - rot_cnt increments on each step in ROT.
  - It is cleared on entry to FWD, on clear in FAULT, and on reset.
  - It is preserved across IDLE and GAP.
- IDLE:
  - req_fwd -> FWD; req_rot -> ROT; else stay.
  - Latency: request sampled at a falling edge; the motor enable is high after that same edge.
- FWD:
  - enable=0 -> IDLE immediately, dwell ignored.
  - Dwell met and req_rot -> GAP with target ROT.
  - Dwell met and no request -> IDLE.
  - Otherwise stay.
- ROT:
  - If this step makes rot_cnt == ROT_LIMIT -> FAULT. This has priority over enable=0 and over all other transitions in the same cycle.
  - Else enable=0 -> IDLE.
  - Else dwell met and req_fwd -> GAP with target FWD.
  - Else dwell met and no request -> IDLE.
  - Otherwise stay.
- GAP:
  - gap_cnt counts GAP cycles with motors off; enable=0 -> IDLE at any point.
  - At expiry, go to the target if it is still requested.
  - At expiry, if the opposite command is now requested, go to that state (no second gap, since motors are already off).
  - At expiry with no request -> IDLE.
- FAULT:
  - Motors off; stays until clear=1, then IDLE with rot_cnt = 0.
  - clear in any other state has no effect.
  - enable has no effect in FAULT.
- Reset mid-operation: asynchronous return to IDLE, outputs 0 with no glitch pulse on step.
- Counter widths: $clog2 of each parameter (+1 where a counter must hold the terminal value); no wrap.
  - rot_cnt saturates at ROT_LIMIT.
  - dwell_cnt saturates at DWELL.

Decomposition:
- Shared package robo_pkg:
  - State encoding constants IDLE/FWD/ROT/GAP/FAULT (3-bit).
  - Default parameter constants shared with the navigation FSM bench.
- One sub-module, robo_step_prescaler: DIV counter with sync zero-on-entry input, run input and one-cycle step output.
- The FSM, dwell, gap and watchdog logic stay in robo_motion_ctrl.

Test Plan:
- Reset, enable=1, avancar=1, girar=0 -> motor_fwd=1 after the first falling edge; step pulses at cycles 8, 16, 24; motor_rot=0 throughout.
- In FWD, girar=1 raised after 1 step -> FWD held until the 4th step, then busy=1 for 2 cycles with both motors 0, then motor_rot=1.
- Both avancar=1 and girar=1 from IDLE -> ROT entered (girar priority).
- ROT_LIMIT=5, girar held -> stuck=1 on the 5th rotate step. Motors stay 0 despite requests; clear=1 -> IDLE, and a subsequent girar allows 5 more steps.
- enable dropped in the middle of FWD dwell (after step 2) -> IDLE on the next edge, step stops; dwell is not enforced.
- Async reset asserted between clock edges during ROT -> motor_rot, step and busy all 0 immediately; state=0.
